// File: rtl/spi_regs_slave.sv
// SPI mode-0 slave with an 8-entry byte register file; all SPI pins are oversampled
// on clk_pll_o, so no logic runs on the SPI clock.
`timescale 1ns/1ps
module spi_regs_slave #(
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic        clk_pll_o,
   input  logic        rst_n,
   input  logic        spi_sck,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic [7:0]  status_in,
   output logic [47:0] regs_out,
   output logic        wr_strobe,
   output logic [2:0]  wr_addr,
   output logic [7:0]  wr_data
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_DATA = 2'd2} state_t;

   state_t      state_r, state_next_s;
   logic        sck_meta_r, sck_sync_r, sck_prev_r;
   logic        cs_meta_r, cs_sync_r, cs_prev_r;
   logic        mosi_meta_r, mosi_sync_r;
   logic        sck_rise_s, sck_fall_s, cs_fall_s, byte_done_s;
   logic [7:0]  rx_byte_s;
   logic [2:0]  addr_inc_s;
   logic [2:0]  bit_cnt_r, addr_r, wr_addr_r;
   logic [6:0]  shift_in_r;
   logic [7:0]  shift_out_r, wr_data_r;
   logic [47:0] regs_r;
   logic        rd_r, wr_strobe_r, miso_oe_r;

   function automatic logic [7:0] read_byte(input logic [2:0] a, input logic [7:0] st,
                                            input logic [47:0] rf);
      logic [7:0] b;
      case (a)
         3'd0:    b = ID_VALUE;
         3'd1:    b = st;
         default: b = rf[{a - 3'd2, 3'b000} +: 8];
      endcase
      return b;
   endfunction

   // Two-flop synchronizers plus previous-value registers for edge detection
   always_ff @(posedge clk_pll_o or negedge rst_n) begin
      if (!rst_n) begin
         sck_meta_r  <= 1'b0;
         sck_sync_r  <= 1'b0;
         sck_prev_r  <= 1'b0;
         // CS chain resets low so a CS held low across reset is not seen as a new falling edge
         cs_meta_r   <= 1'b0;
         cs_sync_r   <= 1'b0;
         cs_prev_r   <= 1'b0;
         mosi_meta_r <= 1'b0;
         mosi_sync_r <= 1'b0;
      end else begin
         sck_meta_r  <= spi_sck;
         sck_sync_r  <= sck_meta_r;
         sck_prev_r  <= sck_sync_r;
         cs_meta_r   <= spi_cs_n;
         cs_sync_r   <= cs_meta_r;
         cs_prev_r   <= cs_sync_r;
         mosi_meta_r <= spi_mosi;
         mosi_sync_r <= mosi_meta_r;
      end
   end

   // Edge detection and next-state logic
   always_comb begin
      sck_rise_s   = sck_sync_r & ~sck_prev_r;
      sck_fall_s   = ~sck_sync_r & sck_prev_r;
      cs_fall_s    = ~cs_sync_r & cs_prev_r;
      rx_byte_s    = {shift_in_r, mosi_sync_r};
      byte_done_s  = sck_rise_s && (bit_cnt_r == 3'd7);
      addr_inc_s   = addr_r + 3'd1;
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: if (cs_fall_s) state_next_s = ST_CMD;
                  else           state_next_s = ST_IDLE;
         ST_CMD:  if (cs_sync_r)        state_next_s = ST_IDLE;
                  else if (byte_done_s) state_next_s = ST_DATA;
                  else                  state_next_s = ST_CMD;
         ST_DATA: if (cs_sync_r) state_next_s = ST_IDLE;
                  else           state_next_s = ST_DATA;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_pll_o or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_next_s;
   end

   // Shift registers, address counter, register file and write commit
   always_ff @(posedge clk_pll_o or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r   <= 3'd0;
         addr_r      <= 3'd0;
         shift_in_r  <= 7'd0;
         shift_out_r <= 8'h00;
         regs_r      <= 48'd0;
         rd_r        <= 1'b0;
         wr_strobe_r <= 1'b0;
         wr_addr_r   <= 3'd0;
         wr_data_r   <= 8'h00;
         miso_oe_r   <= 1'b0;
      end else begin
         wr_strobe_r <= 1'b0;
         miso_oe_r   <= (state_next_s != ST_IDLE);
         if ((state_r == ST_IDLE) || cs_sync_r) begin
            bit_cnt_r   <= 3'd0;
            shift_in_r  <= 7'd0;
            shift_out_r <= 8'h00;
         end else if (sck_rise_s) begin
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            shift_in_r <= rx_byte_s[6:0];
            if (bit_cnt_r == 3'd7) begin
               if (state_r == ST_CMD) begin
                  rd_r        <= rx_byte_s[7];
                  addr_r      <= rx_byte_s[2:0];
                  shift_out_r <= rx_byte_s[7] ? read_byte(rx_byte_s[2:0], status_in, regs_r) : 8'h00;
               end else if (rd_r) begin
                  addr_r      <= addr_inc_s;
                  shift_out_r <= read_byte(addr_inc_s, status_in, regs_r);
               end else begin
                  addr_r <= addr_inc_s;
                  if (addr_r >= 3'd2) begin
                     regs_r[{addr_r - 3'd2, 3'b000} +: 8] <= rx_byte_s;
                     wr_strobe_r <= 1'b1;
                     wr_addr_r   <= addr_r;
                     wr_data_r   <= rx_byte_s;
                  end
               end
            end
         // The fall right after a byte boundary must keep the freshly loaded MSB on MISO
         end else if (sck_fall_s && (state_r == ST_DATA) && rd_r && (bit_cnt_r != 3'd0)) begin
            shift_out_r <= {shift_out_r[6:0], 1'b0};
         end
      end
   end

   assign spi_miso    = shift_out_r[7];
   assign spi_miso_oe = miso_oe_r;
   assign regs_out    = regs_r;
   assign wr_strobe   = wr_strobe_r;
   assign wr_addr     = wr_addr_r;
   assign wr_data     = wr_data_r;

endmodule

// File: tb/tb_spi_regs_slave.sv
// Scoreboard bench for spi_regs_slave: expected commits and read bytes are queued as
// stimulus is driven and popped when the DUT strobes a write or returns a MISO byte.
`timescale 1ns/1ps
module tb_spi_regs_slave;

   logic        clk_pll_o = 1'b0;
   logic        rst_n, spi_sck, spi_cs_n, spi_mosi;
   logic        spi_miso, spi_miso_oe;
   logic [7:0]  status_in;
   logic [47:0] regs_out;
   logic        wr_strobe;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  model_regs [8];
   logic [10:0] exp_wr_q [$];
   logic [7:0]  exp_rd_q [$];
   logic [7:0]  wbuf [4];
   logic [7:0]  rx_byte;
   logic [10:0] mon_e;

   spi_regs_slave #(.ID_VALUE(8'hA5)) dut (
      .clk_pll_o(clk_pll_o), .rst_n(rst_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .status_in(status_in), .regs_out(regs_out), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk_pll_o = ~clk_pll_o;

   task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   function automatic logic [47:0] model_concat();
      return {model_regs[7], model_regs[6], model_regs[5], model_regs[4], model_regs[3], model_regs[2]};
   endfunction

   // Shift nbits of tx MSB-first; SCK = clk/8, MISO captured as SCK rises
   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_sck  = 1'b0;
         spi_mosi = tx[7 - i];
         repeat (4) @(negedge clk_pll_o);
         rx[7 - i] = spi_miso;
         spi_sck   = 1'b1;
         repeat (4) @(negedge clk_pll_o);
      end
   endtask

   task automatic begin_txn();
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk_pll_o);
      check_val("oe_active", {47'd0, spi_miso_oe}, 48'd1);
   endtask

   task automatic end_txn();
      spi_sck = 1'b0;
      repeat (4) @(negedge clk_pll_o);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk_pll_o);
      check_val("oe_idle", {47'd0, spi_miso_oe}, 48'd0);
   endtask

   task automatic write_txn(input logic [2:0] a, input int n);
      logic [2:0] ea;
      begin_txn();
      spi_bits({1'b0, 4'b0000, a}, 8, rx_byte);
      for (int k = 0; k < n; k++) begin
         ea = a + 3'(k);
         if (ea >= 3'd2) begin
            exp_wr_q.push_back({ea, wbuf[k]});
            model_regs[ea] = wbuf[k];
         end
         spi_bits(wbuf[k], 8, rx_byte);
      end
      end_txn();
   endtask

   task automatic read_txn(input logic [2:0] a, input int n);
      logic [2:0] ea;
      logic [7:0] e;
      begin_txn();
      spi_bits({1'b1, 4'b0000, a}, 8, rx_byte);
      for (int k = 0; k < n; k++) begin
         ea = a + 3'(k);
         if (ea == 3'd0)      exp_rd_q.push_back(8'hA5);
         else if (ea == 3'd1) exp_rd_q.push_back(status_in);
         else                 exp_rd_q.push_back(model_regs[ea]);
         spi_bits(8'h00, 8, rx_byte);
         e = exp_rd_q.pop_front();
         check_val($sformatf("rd_addr%0d", ea), {40'd0, rx_byte}, {40'd0, e});
      end
      end_txn();
   endtask

   // Write-commit monitor: each strobe cycle must match the next queued commit
   always @(negedge clk_pll_o) begin
      if (rst_n && wr_strobe) begin
         if (exp_wr_q.size() == 0) begin
            check_val("spurious_strobe", {47'd0, wr_strobe}, 48'd0);
         end else begin
            mon_e = exp_wr_q.pop_front();
            check_val("wr_addr", {45'd0, wr_addr}, {45'd0, mon_e[10:8]});
            check_val("wr_data", {40'd0, wr_data}, {40'd0, mon_e[7:0]});
            check_val("regs_out_at_strobe", {40'd0, regs_out[(int'(mon_e[10:8]) - 2) * 8 +: 8]},
                      {40'd0, mon_e[7:0]});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; status_in = 8'h00;
      foreach (model_regs[i]) model_regs[i] = 8'h00;
      repeat (4) @(negedge clk_pll_o);
      check_val("rst_miso", {47'd0, spi_miso}, 48'd0);
      check_val("rst_oe", {47'd0, spi_miso_oe}, 48'd0);
      check_val("rst_strobe", {47'd0, wr_strobe}, 48'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_pll_o);

      // Commit something first so the mid-transfer reset has state to clear
      wbuf[0] = 8'h99;
      write_txn(3'd5, 1);
      begin_txn();
      spi_bits(8'h03, 8, rx_byte);
      spi_bits(8'h5C, 4, rx_byte);
      rst_n = 1'b0;
      spi_sck = 1'b0;
      @(negedge clk_pll_o);
      check_val("midrst_miso", {47'd0, spi_miso}, 48'd0);
      check_val("midrst_oe", {47'd0, spi_miso_oe}, 48'd0);
      check_val("midrst_strobe", {47'd0, wr_strobe}, 48'd0);
      check_val("midrst_wr_addr", {45'd0, wr_addr}, 48'd0);
      check_val("midrst_wr_data", {40'd0, wr_data}, 48'd0);
      check_val("midrst_regs", regs_out, 48'd0);
      foreach (model_regs[i]) model_regs[i] = 8'h00;
      repeat (3) @(negedge clk_pll_o);
      rst_n = 1'b1;
      repeat (6) @(negedge clk_pll_o);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk_pll_o);
      read_txn(3'd0, 1);

      wbuf[0] = 8'h5C;
      write_txn(3'd3, 1);
      check_val("single_reg3", {40'd0, regs_out[15:8]}, {40'd0, 8'h5C});

      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      write_txn(3'd6, 3);
      check_val("wrap_reg7", {40'd0, regs_out[47:40]}, {40'd0, 8'h22});
      check_val("wrap_reg6", {40'd0, regs_out[39:32]}, {40'd0, 8'h11});

      wbuf[0] = 8'h81;
      write_txn(3'd2, 1);
      status_in = 8'h3C;
      read_txn(3'd0, 3);

      begin_txn();
      spi_bits(8'h04, 8, rx_byte);
      spi_bits(8'hAA, 5, rx_byte);
      end_txn();
      check_val("abort_reg4", {40'd0, regs_out[23:16]}, {40'd0, model_regs[4]});
      wbuf[0] = 8'h7E;
      write_txn(3'd4, 1);
      check_val("after_abort_reg4", {40'd0, regs_out[23:16]}, {40'd0, 8'h7E});

      wbuf[0] = 8'hFF;
      write_txn(3'd1, 1);
      status_in = 8'h5A;
      read_txn(3'd1, 1);

      check_val("final_regs", regs_out, model_concat());
      check_val("pending_commits", 48'(exp_wr_q.size()), 48'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
